// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix multiplier: default widths, the
// product/entry counts and the mapping from product index k to (i, t, j).
package matmul_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int N_PRODUCTS     = 8;
  localparam int N_ENTRIES      = 4;

  typedef logic [2:0] prod_idx_t;
  typedef logic [1:0] entry_idx_t;

  // Result width wide enough for the sum of two full-width products.
  function automatic int acc_width(input int data_w);
    return 2 * data_w + 1;
  endfunction

  // Product k computes A(i,t) * B(t,j) with e = k>>1, i = e>>1, j = e&1, t = k&1.
  function automatic logic prod_i(input prod_idx_t k);
    return k[2];
  endfunction

  function automatic logic prod_j(input prod_idx_t k);
    return k[1];
  endfunction

  function automatic logic prod_t(input prod_idx_t k);
    return k[0];
  endfunction

endpackage

// File: rtl/result_drain.sv
// Output side of the matrix datapath: snapshots the four result entries on a
// rising edge of done and streams them out in index order over valid/ready.
// A done rise that arrives while a drain is in progress is dropped and
// flagged through the sticky overrun bit.
module result_drain
  import matmul_pkg::*;
#(
  parameter int ACC_W = acc_width(DATA_W_DEFAULT)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       done,
  input  logic [N_ENTRIES*ACC_W-1:0] results_flat,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic [1:0]                 out_index,
  output logic                       out_valid,
  output logic                       overrun
);

  logic [ACC_W-1:0] snap [N_ENTRIES];
  logic             done_q;
  logic             done_rise;
  logic             xfer;

  assign done_rise = done && !done_q;
  assign xfer      = out_valid && out_ready;
  assign out_data  = snap[out_index];

  // Snapshot on done rise when idle, advance the index on every transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q    <= 1'b0;
      out_valid <= 1'b0;
      out_index <= 2'd0;
      overrun   <= 1'b0;
      for (int n = 0; n < N_ENTRIES; n++) begin
        snap[n] <= '0;
      end
    end else begin
      done_q <= done;
      if (xfer) begin
        out_index <= out_index + 2'd1;
        if (out_index == 2'd3) begin
          out_valid <= 1'b0;
        end
      end
      // out_valid is still high on the final-transfer edge, so a coincident
      // done rise counts as busy and is dropped.
      if (done_rise) begin
        if (!out_valid) begin
          for (int n = 0; n < N_ENTRIES; n++) begin
            snap[n] <= results_flat[n*ACC_W +: ACC_W];
          end
          out_index <= 2'd0;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_datapath.sv
// Arithmetic datapath of the 2x2 matrix multiplier. Driven by the multiplier
// FSM: one partial product per count value while load_matrix is high, then
// one pairwise sum per entry value, then done hands the results to the drain.
// Operands are not latched; upstream holds a_flat/b_flat stable until done.
module matrix_datapath
  import matmul_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ACC_W  = acc_width(DATA_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_matrix,
  input  logic [3:0]          count,
  input  logic [2:0]          entry,
  input  logic                done,
  input  logic [4*DATA_W-1:0] a_flat,
  input  logic [4*DATA_W-1:0] b_flat,
  output logic [ACC_W-1:0]    out_data,
  output logic [1:0]          out_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam int PROD_W = 2 * DATA_W;

  // Zero-extending pairwise sum; ACC_W >= PROD_W+1 so nothing is lost.
  function automatic logic [ACC_W-1:0] pair_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y);
    return ACC_W'(x) + ACC_W'(y);
  endfunction

  logic [DATA_W-1:0]          a_el [4];
  logic [DATA_W-1:0]          b_el [4];
  prod_idx_t                  prod_k;
  entry_idx_t                 acc_e;
  logic                       prod_en;
  logic                       acc_en;
  logic [1:0]                 a_idx;
  logic [1:0]                 b_idx;
  logic [PROD_W-1:0]          prod_next;
  logic [ACC_W-1:0]           acc_next;
  logic [PROD_W-1:0]          prod_p0 [N_PRODUCTS];
  logic [ACC_W-1:0]           acc_p1  [N_ENTRIES];
  logic [N_ENTRIES*ACC_W-1:0] results_flat;

  // Unpack the flattened operand matrices, element (i,j) at index 2i+j.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      a_el[n] = a_flat[n*DATA_W +: DATA_W];
      b_el[n] = b_flat[n*DATA_W +: DATA_W];
    end
  end

  assign prod_en = load_matrix && (count >= 4'd1) && (count <= 4'd8);
  assign acc_en  = !load_matrix && (entry >= 3'd1) && (entry <= 3'd4);
  assign prod_k  = 3'(count - 4'd1);
  assign acc_e   = 2'(entry - 3'd1);

  assign a_idx     = {prod_i(prod_k), prod_t(prod_k)};
  assign b_idx     = {prod_t(prod_k), prod_j(prod_k)};
  assign prod_next = PROD_W'(a_el[a_idx]) * PROD_W'(b_el[b_idx]);
  assign acc_next  = pair_sum(prod_p0[{acc_e, 1'b0}], prod_p0[{acc_e, 1'b1}]);

  // Stage p0: partial product register selected by count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < N_PRODUCTS; n++) begin
        prod_p0[n] <= '0;
      end
    end else if (prod_en) begin
      prod_p0[prod_k] <= prod_next;
    end
  end

  // Stage p1: result entry register selected by entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < N_ENTRIES; n++) begin
        acc_p1[n] <= '0;
      end
    end else if (acc_en) begin
      acc_p1[acc_e] <= acc_next;
    end
  end

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_results
    assign results_flat[g*ACC_W +: ACC_W] = acc_p1[g];
  end

  result_drain #(
    .ACC_W (ACC_W)
  ) u_drain (
    .clock        (clock),
    .reset        (reset),
    .done         (done),
    .results_flat (results_flat),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

endmodule

// File: doc/matrix_datapath.md
# matrix_datapath

Arithmetic datapath for the 2x2 matrix multiplier. It sits directly downstream of the multiplier control FSM and consumes that FSM's `count`, `load_matrix`, `entry` and `done` outputs. It forms the 8 partial products of C = A x B and sums them pairwise into 4 result entries. On `done` it snapshots C into an output buffer and streams the entries out over a valid/ready handshake.

## Interface
Parameters:
- `DATA_W`, default 8: width of each unsigned A/B element.
- `ACC_W`, default 2*DATA_W+1: width of each result entry. Must hold the sum of two full-width products.

Ports (one clock; reset is synchronous and active-high):
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `load_matrix`, in, 1: multiply phase active (from FSM).
- `count`, in, 4: product index + 1 (from FSM).
- `entry`, in, 3: result entry index + 1 (from FSM).
- `done`, in, 1: results final (from FSM).
- `a_flat`, in, 4*DATA_W: element A(i,j) at bits [(2i+j)*DATA_W +: DATA_W].
- `b_flat`, in, 4*DATA_W: element B(i,j), same packing.
- `out_data`, out, ACC_W: current result entry.
- `out_index`, out, 2: entry number, 2i+j.
- `out_valid`, out, 1: `out_data`/`out_index` valid.
- `out_ready`, in, 1: consumer accepts.
- `overrun`, out, 1: sticky; a `done` rise was dropped.

## Operation
- Product k (0..7): e = k>>1, t = k&1, i = e>>1, j = e&1; p[k] = A(i,t) * B(t,j), unsigned, 2*DATA_W bits.
- Multiply phase: when `load_matrix`=1 and 1 <= `count` <= 8, register p[count-1]. Other `count` values are ignored; the product registers hold.
- Accumulate phase: when `load_matrix`=0 and 1 <= `entry` <= 4, register c[entry-1] = p[2(entry-1)] + p[2(entry-1)+1], zero-extended to ACC_W. No truncation. `entry` of 0 or 5..7 is ignored.
- `a_flat`/`b_flat` must be held stable by the upstream stage from `start` until `done`. The datapath does not latch operands.
- Done detection: rising edge of `done`, i.e. `done`=1 while the registered previous `done`=0.
  - If the drain is idle: copy c[0..3] into the output buffer, set the index to 0, set `out_valid`.
  - If the drain is busy: ignore the new results, keep draining, and set `overrun`=1.
- Drain: a transfer happens on a cycle with `out_valid` && `out_ready`. Each transfer increments the index. The transfer at index 3 clears `out_valid`, and the drain becomes idle.
- `out_valid` stays high with stable data until accepted. It never drops without a transfer.
- `overrun` clears only on `reset`.
- Reset value of every output and register is 0: `out_valid`, `out_data`, `out_index`, `overrun`, p[], c[], buffer, index, previous `done`.

## Timing
- Product register updates on the edge that samples the qualifying `count`: 1-cycle latency.
- Accumulator register updates on the edge that samples the qualifying `entry`: 1-cycle latency.
- `done` rise sampled at edge N: `out_valid`=1 and `out_data`=c[0] are visible after edge N. The buffer snapshots c as registered before edge N.
- Full-rate drain with `out_ready` held at 1: 4 consecutive cycles. `out_valid` is 0 after the 4th accepting edge.
- `done` rise on the same edge as the final (index 3) transfer: drain counts as busy, so the rise is dropped and `overrun` is set.
- `reset` mid-drain: everything is cleared on that edge, with no further valid beats. `reset` has priority over all other inputs.
- `done` held high for many cycles: only the rising edge triggers a snapshot.

## Structure
- Shared package `matmul_pkg`:
  - `DATA_W` default, `ACC_W` derivation.
  - Constants `N_PRODUCTS`=8 and `N_ENTRIES`=4.
  - Index functions from k to (i, t, j).
- The FSM and this block both import `matmul_pkg`.
- One natural sub-module: `result_drain`. It holds the 4-entry snapshot buffer, index counter, valid/ready logic and `overrun`. The top level keeps the product and accumulator registers.

## Test plan
- Basic product: A=[[1,2],[3,4]], B=[[5,6],[7,8]], FSM-driven sequence, `out_ready`=1 -> beats (0,19), (1,22), (2,43), (3,50) on 4 consecutive cycles.
- Maximum values: all elements 255 -> each entry = 130050 (0x1FC02), ACC_W=17, no overflow.
- Backpressure: `out_ready` toggled 1,0,0,1,1,0,1 -> each entry transferred exactly once, in order. Data is stable while `out_ready`=0.
- Overrun: second `done` rise while index=1 -> remaining beats are still from the first result, then `overrun`=1 sticky. A new result is accepted after the drain is idle.
- Out-of-range inputs: `count`=0 and 9 with `load_matrix`=1, `entry`=0 and 5 -> p[] and c[] unchanged.
- Reset mid-drain: `reset` after beat 1 -> `out_valid`=0 next cycle, all outputs 0. A fresh full computation afterwards yields correct results.
